// File: rtl/dbg_bus_pkg.sv
// Shared constants and FSM state type for the UART debug bus master.
package dbg_bus_pkg;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_TMO  = 8'h15;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_STRB = 3'd3,
    S_BUS  = 3'd4,
    S_RESP = 3'd5
  } state_t;

endpackage

// File: rtl/dbg_bus_master_if.sv
// Byte-stream command/response channels plus native memory-bus initiator port.
// Handshake: a byte or bus beat moves on a rising edge where valid and ready are both high;
// the source holds valid and its payload stable until that edge, and ready never depends on a later valid drop.
interface dbg_bus_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_ready, mem_rdata,
    output rx_ready, tx_data, tx_valid,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mem_ready, mem_rdata,
    input  rx_ready, tx_data, tx_valid,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/dbg_resp_ser.sv
// Response serializer: loads one or four bytes and shifts them out LSB first on the tx handshake.
module dbg_resp_ser (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_four,
  input  logic [31:0] i_data,
  input  logic        i_tx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_done
);

  logic [31:0] r_buf;
  logic [2:0]  r_left;
  logic        r_valid;

  assign o_tx_data  = r_buf[7:0];
  assign o_tx_valid = r_valid;
  assign o_done     = r_valid && i_tx_ready && (r_left == 3'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf   <= 32'h0;
      r_left  <= 3'd0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_buf   <= i_data;
      r_left  <= i_four ? 3'd4 : 3'd1;
      r_valid <= 1'b1;
    end else if (r_valid && i_tx_ready) begin
      // Next byte is presented on the same edge the current one is taken: no bubble.
      if (r_left == 3'd1) begin
        r_valid <= 1'b0;
        r_left  <= 3'd0;
      end else begin
        r_buf  <= {8'h00, r_buf[31:8]};
        r_left <= r_left - 3'd1;
      end
    end
  end

endmodule

// File: rtl/dbg_bus_master.sv
// UART-command driven memory-bus master: parses read/write frames, runs one bus cycle, returns a response.
module dbg_bus_master
  import dbg_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  dbg_bus_master_if.master        bus,
  output state_t                  o_state
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_rx_ready;
  logic        r_is_write;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_mem_valid;
  logic [15:0] r_tmo_cnt;
  logic        r_load;
  logic        r_resp_four;
  logic [31:0] r_resp_data;

  logic        w_rx_fire;
  logic        w_done;
  logic [7:0]  w_tx_data;
  logic        w_tx_valid;

  assign w_rx_fire = bus.rx_valid && r_rx_ready;

  assign bus.rx_ready  = r_rx_ready;
  assign bus.tx_data   = w_tx_data;
  assign bus.tx_valid  = w_tx_valid;
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = {r_addr[31:2], 2'b00};
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wstrb = r_wstrb;
  assign o_state       = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rx_ready  <= 1'b0;
      r_is_write  <= 1'b0;
      r_byte_cnt  <= 2'd0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_wstrb     <= 4'h0;
      r_mem_valid <= 1'b0;
      r_tmo_cnt   <= 16'h0;
      r_load      <= 1'b0;
      r_resp_four <= 1'b0;
      r_resp_data <= 32'h0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rx_ready <= 1'b1;
          if (w_rx_fire) begin
            if (bus.rx_data == OP_READ || bus.rx_data == OP_WRITE) begin
              r_is_write <= (bus.rx_data == OP_WRITE);
              r_wdata    <= 32'h0;
              r_wstrb    <= 4'h0;
              r_byte_cnt <= 2'd0;
              r_state    <= S_ADDR;
            end else begin
              r_rx_ready  <= 1'b0;
              r_load      <= 1'b1;
              r_resp_four <= 1'b0;
              r_resp_data <= {24'h0, RSP_ERR};
              r_state     <= S_RESP;
            end
          end
        end
        S_ADDR: begin
          if (w_rx_fire) begin
            r_addr     <= {bus.rx_data, r_addr[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              if (r_is_write) begin
                r_state <= S_DATA;
              end else begin
                r_rx_ready <= 1'b0;
                r_state    <= S_BUS;
              end
            end
          end
        end
        S_DATA: begin
          if (w_rx_fire) begin
            r_wdata    <= {bus.rx_data, r_wdata[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) r_state <= S_STRB;
          end
        end
        S_STRB: begin
          if (w_rx_fire) begin
            r_wstrb    <= bus.rx_data[3:0];
            r_rx_ready <= 1'b0;
            r_state    <= S_BUS;
          end
        end
        S_BUS: begin
          // First BUS cycle raises mem_valid; later cycles wait for ready or the timeout.
          if (!r_mem_valid) begin
            r_mem_valid <= 1'b1;
            r_tmo_cnt   <= 16'h0;
          end else if (bus.mem_ready) begin
            r_mem_valid <= 1'b0;
            r_load      <= 1'b1;
            r_resp_four <= !r_is_write;
            r_resp_data <= r_is_write ? {24'h0, RSP_ACK} : bus.mem_rdata;
            r_state     <= S_RESP;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_mem_valid <= 1'b0;
            r_load      <= 1'b1;
            r_resp_four <= 1'b0;
            r_resp_data <= {24'h0, RSP_TMO};
            r_state     <= S_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'h1;
          end
        end
        S_RESP: begin
          if (w_done) begin
            r_rx_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_rx_ready  <= 1'b0;
          r_mem_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  dbg_resp_ser u_resp_ser (
    .clk        (clk),
    .reset      (reset),
    .i_load     (r_load),
    .i_four     (r_resp_four),
    .i_data     (r_resp_data),
    .i_tx_ready (bus.tx_ready),
    .o_tx_data  (w_tx_data),
    .o_tx_valid (w_tx_valid),
    .o_done     (w_done)
  );

endmodule

// File: doc/dbg_bus_master.md
DBG_BUS_MASTER -- requirements
Module: dbg_bus_master

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 1024: bus cycles waited for mem_ready before abort; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1: single clock for all logic.
REQ-003 SHALL have port reset, input, 1: one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port rx_data, input, 8: command byte from the UART receive side.
REQ-005 SHALL have port rx_valid, input, 1: rx_data holds a byte.
REQ-006 SHALL have port rx_ready, output, 1: the block accepts a byte; a transfer occurs when rx_valid and rx_ready are both high.
REQ-007 SHALL have port tx_data, output, 8: response byte to the UART transmit side.
REQ-008 SHALL have port tx_valid, output, 1: tx_data holds a byte.
REQ-009 SHALL have port tx_ready, input, 1: the sink takes tx_data when tx_valid is high.
REQ-010 SHALL have ports mem_valid (output, 1), mem_instr (output, 1), mem_addr (output, 32), mem_wdata (output, 32), mem_wstrb (output, 4), mem_ready (input, 1) and mem_rdata (input, 32), forming a native memory-bus initiator port.

Function
REQ-011 SHALL parse these frames, multi-byte fields LSB first:
- Read: 0x52, addr[4].
- Write: 0x57, addr[4], data[4], strb[1]; the low nibble of strb is used.
REQ-012 SHALL use FSM states IDLE, ADDR, DATA, STRB, BUS, RESP.
- IDLE -> ADDR on opcode 0x52/0x57.
- ADDR -> DATA (write) or BUS (read) after 4 bytes.
- DATA -> STRB after 4 bytes.
- STRB -> BUS.
- BUS -> RESP.
- RESP -> IDLE after the last response byte transfers.
REQ-013 SHALL drive rx_ready high only in IDLE, ADDR, DATA and STRB; rx_valid in other states SHALL be left pending, never dropped.
REQ-014 SHALL discard an unknown opcode in IDLE, queue the single response byte 0x3F, and go to RESP.
REQ-015 SHALL drive mem_addr[1:0] to 2'b00 regardless of the received address bits.
REQ-016 SHALL assert mem_valid on the cycle after the state enters BUS.
REQ-017 SHALL hold mem_addr, mem_wdata and mem_wstrb stable while mem_valid is high.
REQ-018 SHALL drive mem_wstrb to 4'h0 for reads and to strb[3:0] for writes.
REQ-019 SHALL tie mem_instr to 0.
REQ-020 SHALL, on the first rising edge at which mem_ready is sampled high with mem_valid high, deassert mem_valid on the next cycle and capture mem_rdata on that edge.
REQ-021 SHALL count cycles with mem_valid high using a 16-bit counter; when the count reaches TIMEOUT_CYCLES without mem_ready, it SHALL deassert mem_valid and respond 0x15 only.
REQ-022 SHALL respond with 4 captured read-data bytes, LSB first, for a successful read, and with 0x06 for a successful write.
REQ-023 SHALL hold tx_valid and tx_data stable until tx_ready is high; it SHALL present one byte per cycle at most, and there SHALL be no tx bubble between consecutive response bytes when tx_ready stays high.
REQ-024 SHALL let a strb value of 0 still issue the bus cycle with mem_wstrb 4'h0; the response SHALL be 0x06.
REQ-025 SHALL keep one transaction outstanding at most and SHALL not accept new rx bytes until RESP completes.

Reset
REQ-026 SHALL, while reset is high, force the state to IDLE and set these outputs:
- rx_ready 0, tx_valid 0, tx_data 8'h00.
- mem_valid 0, mem_instr 0, mem_addr 0, mem_wdata 0, mem_wstrb 4'h0.
REQ-027 SHALL, after reset deasserts, drive rx_ready high on the first clk edge.
REQ-028 SHALL abandon any partial frame, bus cycle or response when reset asserts mid-operation, with no further bytes emitted.

Structure
REQ-029 SHALL place the opcode constants (0x52, 0x57), the response codes (0x06, 0x15, 0x3F) and the FSM state enum in the shared package dbg_bus_pkg.
REQ-030 SHALL implement response byte sequencing (load of 1 or 4 bytes, shift-out with tx handshake) in one sub-module, dbg_resp_ser; all other logic SHALL stay flat.

Verification
REQ-031 SHALL cover a write frame 57 00 01 00 80 55 00 00 00 0F with mem_ready asserted 3 cycles after mem_valid -> mem_addr 80000100, mem_wdata 00000055, mem_wstrb F, single-cycle mem_valid drop after ready, then tx byte 06.
REQ-032 SHALL cover a read frame 52 13 00 00 00 with mem_rdata DEADBEEF on ready -> mem_addr 00000010, mem_wstrb 0, tx bytes EF BE AD DE.
REQ-033 SHALL cover a read of 80001000 with mem_ready never asserted and TIMEOUT_CYCLES=8 -> mem_valid high exactly 8 cycles, tx byte 15, FSM back in IDLE.
REQ-034 SHALL cover opcode 0xA5 followed by a valid read frame -> tx 3F, then a correct 4-byte read response.
REQ-035 SHALL cover tx_ready held low 20 cycles during a read response -> tx_data/tx_valid stable throughout, rx_ready 0, all 4 bytes delivered in order afterwards.
REQ-036 SHALL cover reset asserted after 3 address bytes, then released -> no bus cycle, no tx byte, and the next complete write frame is processed normally.
